mem_port2_arbiter: RTL and testbench

Cycle-level arbiter that shares memory port 2 between the CPU control FSM and an external requester: the program loader or debug reader. It sits between the Control block's port-2 outputs (MemDst2 address, MemRead2, MemWrite2) and the memory. It registers one access per cycle onto the port, returns read data with a per-requester valid strobe, and raises a stall to the control FSM whenever the CPU's request is not served.

---
 rtl/memarb_pkg.sv | 17 +
 rtl/memarb_starve_ctr.sv | 36 +++
 rtl/mem_port2_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port2_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// Shared types and constants for the memory port-2 arbiter: owner-state encoding,
// owner tags carried with each access, and the default starvation limit.
package memarb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CPU        = 2'd1,
    EXT        = 2'd2,
    EXT_LOCKED = 2'd3
  } own_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  localparam int MAX_WAIT_DEF = 8;

endpackage

// File: rtl/memarb_starve_ctr.sv
// Saturating refusal counter for the external requester; expired stays high
// while the count sits at MAX_WAIT, and clr takes precedence over inc.
module memarb_starve_ctr
  import memarb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != LIMIT))
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port2_arbiter.sv
// Shares memory port 2 between the CPU control FSM and an external requester.
// Define MEMARB_STARVE_GUARD_EN to add the starvation counter that forces an ext win.
module mem_port2_arbiter
  import memarb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              CLK,
  input  logic              CtrlRst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 255)) begin : g_bad_max_wait
    $error("MAX_WAIT must lie in 1..255");
  end

  own_state_e st_q, st_d;
  logic sel_cpu, sel_ext, force_ext;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic              own_q, own_d;
  logic              cpu_gnt_q, cpu_gnt_d, ext_gnt_q, ext_gnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d, ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] cpu_rhold_q, cpu_rhold_d, ext_rhold_q, ext_rhold_d;

`ifdef MEMARB_STARVE_GUARD_EN
  memarb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk     (CLK),
    .rst_n   (CtrlRst),
    .inc     (ext_req && !sel_ext),
    .clr     (sel_ext),
    .expired (force_ext)
  );
`else
  assign force_ext = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!CtrlRst)
      st_q <= IDLE;
    else
      st_q <= st_d;
  end

  // A locked owner keeps the port only while it still requests with lock held.
  always_comb begin
    sel_cpu = 1'b0;
    sel_ext = 1'b0;
    if ((st_q == EXT_LOCKED) && ext_req && ext_lock)
      sel_ext = 1'b1;
    else if (ext_req && force_ext)
      sel_ext = 1'b1;
    else if (cpu_req)
      sel_cpu = 1'b1;
    else if (ext_req)
      sel_ext = 1'b1;

    st_d = IDLE;
    if (sel_cpu)
      st_d = CPU;
    else if (sel_ext)
      st_d = ext_lock ? EXT_LOCKED : EXT;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    own_d       = own_q;
    cpu_gnt_d   = sel_cpu;
    ext_gnt_d   = sel_ext;
    if (sel_cpu) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_we_d    = cpu_we;
      mem_re_d    = !cpu_we;
      own_d       = OWN_CPU;
    end else if (sel_ext) begin
      mem_addr_d  = ext_addr;
      mem_wdata_d = ext_wdata;
      mem_we_d    = ext_we;
      mem_re_d    = !ext_we;
      own_d       = OWN_EXT;
    end

    // Read data arrives one cycle after mem_re; route it by the tag of that read.
    cpu_rvalid_d = mem_re_q && (own_q == OWN_CPU);
    ext_rvalid_d = mem_re_q && (own_q == OWN_EXT);
    cpu_rdata    = cpu_rvalid_q ? mem_rdata : cpu_rhold_q;
    ext_rdata    = ext_rvalid_q ? mem_rdata : ext_rhold_q;
    cpu_rhold_d  = cpu_rdata;
    ext_rhold_d  = ext_rdata;
    cpu_stall    = cpu_req && !sel_cpu;
  end

  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      own_q        <= OWN_CPU;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rhold_q  <= '0;
      ext_rhold_q  <= '0;
    end else begin
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      own_q        <= own_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ext_gnt_q    <= ext_gnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ext_rvalid_q <= ext_rvalid_d;
      cpu_rhold_q  <= cpu_rhold_d;
      ext_rhold_q  <= ext_rhold_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign cpu_gnt    = cpu_gnt_q;
  assign ext_gnt    = ext_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter with a one-cycle-latency memory model.
module tb_mem_port2_arbiter;

  logic        CLK = 1'b0;
  logic        CtrlRst;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_stall, ext_gnt, ext_rvalid;
  logic [15:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] tmem [0:255];

  int n_cmp = 0;
  int n_err = 0;

  mem_port2_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(8)) dut (
    .CLK(CLK), .CtrlRst(CtrlRst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  // Memory answers a read on the following cycle; otherwise shows a poison value.
  always @(posedge CLK) begin
    if (mem_re) mem_rdata <= tmem[mem_addr[7:0]];
    else        mem_rdata <= 16'hDEAD;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = 16'h0; ext_wdata = 16'h0;
    ext_lock = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    CtrlRst = 1'b0;
    tick();
    tick();
    CtrlRst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    CtrlRst = 1'b0;
    cpu_req = 1'b1; cpu_addr = 16'h0011;
    ext_req = 1'b1; ext_addr = 16'h0022;
    tick();
    tick();
    n_cmp++;
    if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_we, mem_re} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, mem_we, mem_re});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, cpu_rdata, ext_rdata});
    end
    CtrlRst = 1'b1;
    tick();
    n_cmp++;
    if ({cpu_gnt, ext_gnt, mem_re, mem_addr} !== {3'b101, 16'h0011}) begin
      n_err++;
      $display("FAIL reset_release_gnt: got %b/%b/%b/%h want 1/0/1/0011",
               cpu_gnt, ext_gnt, mem_re, mem_addr);
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    tick();
    cpu_req = 1'b0;
    CtrlRst = 1'b0;
    tick();
    n_cmp++;
    if ({cpu_rvalid, ext_rvalid, mem_re, cpu_rdata} !== {3'b000, 16'h0}) begin
      n_err++;
      $display("FAIL reset_mid_read: rvalid %b/%b re %b rdata %h want 0/0/0/0000",
               cpu_rvalid, ext_rvalid, mem_re, cpu_rdata);
    end
    CtrlRst = 1'b1;
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
    tick();
    cpu_req = 1'b0;
    n_cmp++;
    if ({cpu_gnt, mem_re, mem_we, mem_addr} !== {3'b110, 16'h0040}) begin
      n_err++;
      $display("FAIL cpu_read_issue: gnt %b re %b we %b addr %h want 1/1/0/0040",
               cpu_gnt, mem_re, mem_we, mem_addr);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata} !== {2'b10, 16'hBEEF, 16'h0}) begin
      n_err++;
      $display("FAIL cpu_read_return: rv %b/%b rdata %h/%h want 1/0 BEEF/0000",
               cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, cpu_rdata, mem_re, cpu_gnt} !== {1'b0, 16'hBEEF, 2'b00}) begin
      n_err++;
      $display("FAIL cpu_read_hold: rv %b rdata %h re %b gnt %b want 0 BEEF 0 0",
               cpu_rvalid, cpu_rdata, mem_re, cpu_gnt);
    end
  endtask

  task automatic test_contention();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0001;
    ext_req = 1'b1; ext_addr = 16'h0002;
`ifdef MEMARB_STARVE_GUARD_EN
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        tick();
        n_cmp++;
        if ({cpu_gnt, ext_gnt, cpu_stall} !== {2'b10, (i == 7)}) begin
          n_err++;
          $display("FAIL contention_cpu r%0d c%0d: gnt %b/%b stall %b want 1/0/%0d",
                   r, i, cpu_gnt, ext_gnt, cpu_stall, (i == 7));
        end
      end
      tick();
      n_cmp++;
      if ({cpu_gnt, ext_gnt, mem_addr} !== {2'b01, 16'h0002}) begin
        n_err++;
        $display("FAIL contention_ext r%0d: gnt %b/%b addr %h want 0/1/0002",
                 r, cpu_gnt, ext_gnt, mem_addr);
      end
    end
`else
    for (int i = 0; i < 50; i++) begin
      tick();
      n_cmp++;
      if ({cpu_gnt, ext_gnt, cpu_stall} !== 3'b100) begin
        n_err++;
        $display("FAIL contention_noguard c%0d: gnt %b/%b stall %b want 1/0/0",
                 i, cpu_gnt, ext_gnt, cpu_stall);
      end
    end
`endif
    clear_inputs();
    tick();
  endtask

  task automatic test_locked_burst();
    do_reset();
    ext_req = 1'b1; ext_we = 1'b1; ext_lock = 1'b1;
    ext_addr = 16'h0100; ext_wdata = 16'hA000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if ({ext_gnt, cpu_gnt, mem_we, mem_re, mem_addr, mem_wdata} !==
          {4'b1010, 16'h0100 + 16'(k), 16'hA000 + 16'(k)}) begin
        n_err++;
        $display("FAIL locked_write k%0d: gnt %b/%b we %b re %b addr %h wd %h", k,
                 ext_gnt, cpu_gnt, mem_we, mem_re, mem_addr, mem_wdata);
      end
      if (k < 3) begin
        cpu_req = 1'b1; cpu_addr = 16'h0055;
        ext_addr = 16'h0101 + 16'(k); ext_wdata = 16'hA001 + 16'(k);
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b1) begin
          n_err++;
          $display("FAIL locked_stall k%0d: stall %b want 1", k, cpu_stall);
        end
      end else begin
        ext_req = 1'b0; ext_lock = 1'b0; ext_we = 1'b0;
      end
    end
    tick();
    n_cmp++;
    if ({cpu_gnt, ext_gnt, mem_re, mem_addr} !== {3'b101, 16'h0055}) begin
      n_err++;
      $display("FAIL locked_release: gnt %b/%b re %b addr %h want 1/0/1/0055",
               cpu_gnt, ext_gnt, mem_re, mem_addr);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_interleaved();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0010;
    tick();
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_addr = 16'h0020;
    tick();
    ext_req = 1'b0;
    n_cmp++;
    if ({ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata} !== {3'b110, 16'h1111}) begin
      n_err++;
      $display("FAIL interleave_cpu: egnt %b rv %b/%b crdata %h want 1/1/0 1111",
               ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata);
    end
    tick();
    n_cmp++;
    if ({cpu_rvalid, ext_rvalid, ext_rdata, cpu_rdata} !== {2'b01, 16'h2222, 16'h1111}) begin
      n_err++;
      $display("FAIL interleave_ext: rv %b/%b rdata %h/%h want 0/1 2222/1111",
               cpu_rvalid, ext_rvalid, ext_rdata, cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cpu_req = 1'b1; cpu_addr = 16'h0041;
    tick();
    cpu_req = 1'b0;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 16'h0030; ext_wdata = 16'h5A5A;
    tick();
    n_cmp++;
    if ({ext_gnt, mem_we, mem_re, cpu_rvalid, cpu_rdata} !== {4'b1101, 16'hA541}) begin
      n_err++;
      $display("FAIL b2b_write: gnt %b we %b re %b crv %b crdata %h want 1/1/0/1 A541",
               ext_gnt, mem_we, mem_re, cpu_rvalid, cpu_rdata);
    end
    ext_we = 1'b0; ext_addr = 16'h0042;
    tick();
    ext_req = 1'b0;
    n_cmp++;
    if ({ext_gnt, mem_re, cpu_rvalid, ext_rvalid} !== 4'b1100) begin
      n_err++;
      $display("FAIL b2b_after_write: gnt %b re %b rv %b/%b want 1/1/0/0",
               ext_gnt, mem_re, cpu_rvalid, ext_rvalid);
    end
    tick();
    n_cmp++;
    if ({ext_rvalid, cpu_rvalid, ext_rdata} !== {2'b10, 16'hA542}) begin
      n_err++;
      $display("FAIL b2b_ext_read: rv %b/%b erdata %h want 1/0 A542",
               ext_rvalid, cpu_rvalid, ext_rdata);
    end
    n_cmp++;
    if ({mem_we, mem_re, cpu_gnt, ext_gnt, mem_addr} !== {4'b0000, 16'h0042}) begin
      n_err++;
      $display("FAIL idle_hold: we %b re %b gnt %b/%b addr %h want 0/0/0/0 0042",
               mem_we, mem_re, cpu_gnt, ext_gnt, mem_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) tmem[i] = 16'hA500 | 16'(i);
    tmem[8'h40] = 16'hBEEF;
    tmem[8'h10] = 16'h1111;
    tmem[8'h20] = 16'h2222;
    CtrlRst = 1'b0;
    clear_inputs();

    test_reset();
    test_reset_mid_read();
    test_cpu_read();
    test_contention();
    test_locked_burst();
    test_interleaved();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
